// File: rtl/usb_wire_dir_ctrl_if.sv
// Handshake bundle between the serial interface engine processes and the wire-direction controller.
// The master side (TX engine, getPacket processes, wire-data reader) drives requests; the controller is the slave.
interface usb_wire_dir_ctrl_if;
    logic txReq;
    logic txDone;
    logic rxWaitReq;
    logic RxWireActive;
    logic noActivityTimeOut;
    logic txGnt;
    logic TxWireActiveDrive;
    logic noActivityTimeOutEnable;
    logic rxDone;
    logic rxTimeOut;

    modport master (
        output txReq, txDone, rxWaitReq, RxWireActive, noActivityTimeOut,
        input  txGnt, TxWireActiveDrive, noActivityTimeOutEnable, rxDone, rxTimeOut
    );

    modport slave (
        input  txReq, txDone, rxWaitReq, RxWireActive, noActivityTimeOut,
        output txGnt, TxWireActiveDrive, noActivityTimeOutEnable, rxDone, rxTimeOut
    );
endinterface

// File: rtl/usb_wire_dir_ctrl.sv
// Arbitrates the shared USB D+/D- pair between transmitter and receive path,
// inserting a speed-dependent turnaround gap after every packet in either direction.
module usb_wire_dir_ctrl #(
    parameter int FS_GAP_CNT = 8,
    parameter int LS_GAP_CNT = 64,
    parameter int GAP_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fullSpeedRate,
    usb_wire_dir_ctrl_if.slave   bus,
    output logic                 busy,
    output logic [2:0]           ctrlState
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] TX_ACT  = 3'd1;
    localparam logic [2:0] TX_GAP  = 3'd2;
    localparam logic [2:0] RX_WAIT = 3'd3;
    localparam logic [2:0] RX_ACT  = 3'd4;
    localparam logic [2:0] RX_GAP  = 3'd5;

    localparam logic [GAP_W-1:0] FS_LOAD = GAP_W'(FS_GAP_CNT - 1);
    localparam logic [GAP_W-1:0] LS_LOAD = GAP_W'(LS_GAP_CNT - 1);

    logic [2:0]       state_q, state_d;
    logic [GAP_W-1:0] cnt_q, cnt_d;
    logic             rxDone_q, rxDone_d;
    logic             rxTimeOut_q, rxTimeOut_d;
    logic             txGnt_q, txDrive_q, toEn_q, busy_q;
    logic [GAP_W-1:0] gap_load;

    // Speed is latched only at gap entry; later changes cannot stretch or shorten a running gap.
    assign gap_load = fullSpeedRate ? FS_LOAD : LS_LOAD;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rxDone_d    = 1'b0;
        rxTimeOut_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.txReq) begin
                    state_d = TX_ACT;
                end else if (bus.rxWaitReq) begin
                    state_d = RX_WAIT;
                end
            end
            TX_ACT: begin
                if (bus.txDone) begin
                    state_d = TX_GAP;
                    cnt_d   = gap_load;
                end
            end
            TX_GAP, RX_GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - GAP_W'(1);
                end
            end
            RX_WAIT: begin
                // Wire activity beats a simultaneous timeout: a packet is arriving.
                if (bus.RxWireActive) begin
                    state_d = RX_ACT;
                end else if (bus.noActivityTimeOut) begin
                    state_d     = IDLE;
                    rxTimeOut_d = 1'b1;
                end else if (!bus.rxWaitReq) begin
                    state_d = IDLE;
                end
            end
            RX_ACT: begin
                if (!bus.RxWireActive) begin
                    state_d  = RX_GAP;
                    cnt_d    = gap_load;
                    rxDone_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rxDone_q    <= 1'b0;
            rxTimeOut_q <= 1'b0;
            txGnt_q     <= 1'b0;
            txDrive_q   <= 1'b0;
            toEn_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rxDone_q    <= rxDone_d;
            rxTimeOut_q <= rxTimeOut_d;
            txGnt_q     <= (state_d == TX_ACT);
            txDrive_q   <= (state_d == TX_ACT);
            toEn_q      <= (state_d == RX_WAIT);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign bus.txGnt                   = txGnt_q;
    assign bus.TxWireActiveDrive       = txDrive_q;
    assign bus.noActivityTimeOutEnable = toEn_q;
    assign bus.rxDone                  = rxDone_q;
    assign bus.rxTimeOut               = rxTimeOut_q;
    assign busy                        = busy_q;
    assign ctrlState                   = state_q;

endmodule

// File: tb/tb_usb_wire_dir_ctrl.sv
// Bench for usb_wire_dir_ctrl: directed scenarios with literal expectations plus randomized
// traffic, all outputs compared every cycle against a behavioural model of the wire owner.
module tb_usb_wire_dir_ctrl;

    logic       clk;
    logic       rst;
    logic       fullSpeedRate;
    logic       busy;
    logic [2:0] ctrlState;

    usb_wire_dir_ctrl_if bus ();

    usb_wire_dir_ctrl #(
        .FS_GAP_CNT(8),
        .LS_GAP_CNT(64),
        .GAP_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fullSpeedRate(fullSpeedRate),
        .bus(bus.slave),
        .busy(busy),
        .ctrlState(ctrlState)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    initial clk = 0;
    always #5 clk = ~clk;

    // Behavioural model: who owns the wire and how many gap cycles remain.
    int m_owner = 0;   // 0 idle,1 tx,2 tx gap,3 waiting rx,4 rx,5 rx gap
    int m_gap_left = 0;
    bit m_rxDone = 0;
    bit m_rxTO = 0;

    task automatic model_step();
        if (!rst) begin
            m_owner = 0; m_gap_left = 0; m_rxDone = 0; m_rxTO = 0;
        end else begin
            m_rxDone = 0;
            m_rxTO = 0;
            if (m_owner == 0) begin
                if (bus.txReq) m_owner = 1;
                else if (bus.rxWaitReq) m_owner = 3;
            end else if (m_owner == 1) begin
                if (bus.txDone) begin
                    m_owner = 2;
                    m_gap_left = fullSpeedRate ? 8 : 64;
                end
            end else if (m_owner == 2 || m_owner == 5) begin
                m_gap_left = m_gap_left - 1;
                if (m_gap_left == 0) m_owner = 0;
            end else if (m_owner == 3) begin
                if (bus.RxWireActive) m_owner = 4;
                else if (bus.noActivityTimeOut) begin m_rxTO = 1; m_owner = 0; end
                else if (!bus.rxWaitReq) m_owner = 0;
            end else if (m_owner == 4) begin
                if (!bus.RxWireActive) begin
                    m_rxDone = 1;
                    m_owner = 5;
                    m_gap_left = fullSpeedRate ? 8 : 64;
                end
            end
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("txGnt", int'(bus.txGnt), int'(m_owner == 1));
                chk("TxWireActiveDrive", int'(bus.TxWireActiveDrive), int'(m_owner == 1));
                chk("noActivityTimeOutEnable", int'(bus.noActivityTimeOutEnable), int'(m_owner == 3));
                chk("busy", int'(busy), int'(m_owner != 0));
                chk("ctrlState", int'(ctrlState), m_owner);
                chk("rxDone", int'(bus.rxDone), int'(m_rxDone));
                chk("rxTimeOut", int'(bus.rxTimeOut), int'(m_rxTO));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.txReq = 0; bus.txDone = 0; bus.rxWaitReq = 0;
        bus.RxWireActive = 0; bus.noActivityTimeOut = 0;
    endtask

    initial begin
        rst = 0;
        fullSpeedRate = 1;
        idle_inputs();
        repeat (3) tick();
        chk_en = 1;
        chk("reset busy", int'(busy), 0);
        chk("reset ctrlState", int'(ctrlState), 0);
        chk("reset txGnt", int'(bus.txGnt), 0);
        rst = 1;
        tick();

        // Full-speed transmit and its 8-cycle gap
        bus.txReq = 1;
        tick();
        chk("t1 txGnt", int'(bus.txGnt), 1);
        chk("t1 drive", int'(bus.TxWireActiveDrive), 1);
        bus.txReq = 0; bus.txDone = 1;
        tick();
        bus.txDone = 0;
        chk("t1 txGnt off", int'(bus.txGnt), 0);
        chk("t1 drive off", int'(bus.TxWireActiveDrive), 0);
        chk("t1 gap state", int'(ctrlState), 2);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("t1 gap busy", int'(busy), 1);
        end
        tick();
        chk("t1 idle", int'(ctrlState), 0);
        chk("t1 busy off", int'(busy), 0);

        // Simultaneous requests: TX wins, RX served after the gap
        bus.txReq = 1; bus.rxWaitReq = 1;
        tick();
        chk("t2 tx first", int'(ctrlState), 1);
        bus.txReq = 0; bus.txDone = 1;
        tick();
        bus.txDone = 0;
        repeat (8) tick();
        chk("t2 idle after gap", int'(ctrlState), 0);
        tick();
        chk("t2 rx wait", int'(ctrlState), 3);
        chk("t2 to enable", int'(bus.noActivityTimeOutEnable), 1);

        // Low-speed response timeout
        fullSpeedRate = 0;
        bus.noActivityTimeOut = 1;
        tick();
        bus.noActivityTimeOut = 0; bus.rxWaitReq = 0;
        chk("t3 rxTimeOut", int'(bus.rxTimeOut), 1);
        chk("t3 idle", int'(ctrlState), 0);
        chk("t3 rxDone", int'(bus.rxDone), 0);
        tick();
        chk("t3 pulse end", int'(bus.rxTimeOut), 0);

        // Activity beats timeout, then low-speed gap with a pending TX request
        bus.rxWaitReq = 1;
        tick();
        bus.RxWireActive = 1; bus.noActivityTimeOut = 1;
        tick();
        bus.noActivityTimeOut = 0;
        chk("t4 rx act", int'(ctrlState), 4);
        chk("t4 no timeout", int'(bus.rxTimeOut), 0);
        chk("t4 to enable off", int'(bus.noActivityTimeOutEnable), 0);
        bus.txReq = 1; bus.rxWaitReq = 0;
        tick();
        chk("t5 held in rx", int'(bus.txGnt), 0);
        bus.RxWireActive = 0;
        tick();
        chk("t4 rxDone", int'(bus.rxDone), 1);
        chk("t4 rx gap", int'(ctrlState), 5);
        tick();
        chk("t4 rxDone end", int'(bus.rxDone), 0);
        repeat (62) tick();
        chk("t5 still gap", int'(ctrlState), 5);
        chk("t5 no gnt in gap", int'(bus.txGnt), 0);
        tick();
        chk("t5 idle", int'(ctrlState), 0);
        chk("t5 no gnt idle", int'(bus.txGnt), 0);
        tick();
        chk("t5 gnt", int'(bus.txGnt), 1);

        // Reset mid-transmit
        rst = 0;
        tick();
        chk("t6 drive drop", int'(bus.TxWireActiveDrive), 0);
        chk("t6 state", int'(ctrlState), 0);
        tick();
        chk("t6 held busy", int'(busy), 0);
        rst = 1;
        tick();
        chk("t6 rearb", int'(ctrlState), 1);
        bus.txReq = 0; bus.txDone = 1;
        tick();
        bus.txDone = 0;

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            bus.txReq = ($urandom_range(0, 3) == 0);
            bus.txDone = ($urandom_range(0, 5) == 0);
            bus.rxWaitReq = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 4) == 0) bus.RxWireActive = ~bus.RxWireActive;
            bus.noActivityTimeOut = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 29) == 0) fullSpeedRate = ~fullSpeedRate;
            rst = ($urandom_range(0, 199) != 0);
            tick();
        end
        rst = 1;
        idle_inputs();
        repeat (80) tick();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
